// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search block.
package sar_pkg;

   localparam int unsigned WidthDefault = 4;

   typedef enum logic [1:0] {
      StIdle,
      StSearch,
      StDone
   } state_e;

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search driving an external comparator, MSB first.
// Optional macro SAR_SEARCH_EARLY_EXIT_EN: finish as soon as aeb is seen.
module sar_search
   import sar_pkg::*;
#(
   parameter int unsigned WIDTH = WidthDefault
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         agb,
   input  logic                         aeb,
   input  logic                         alb,
   output logic [WIDTH-1:0]             guess,
   output logic                         busy,
   output logic                         done,
   output logic [WIDTH-1:0]             result,
   output logic [$clog2(WIDTH+1)-1:0]   steps,
   output logic                         err
);

   localparam int unsigned SW = $clog2(WIDTH + 1);
   localparam int unsigned IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] guess_q, guess_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [IW-1:0]    bit_idx_q, bit_idx_d;
   logic [SW-1:0]    cnt_q, cnt_d;
   logic [SW-1:0]    steps_q, steps_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] upd;
   logic [SW-1:0]    cnt_inc;
   logic             legal;
   logic             hit;

   always_comb begin
      state_d   = state_q;
      guess_d   = guess_q;
      result_d  = result_q;
      bit_idx_d = bit_idx_q;
      cnt_d     = cnt_q;
      steps_d   = steps_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;

      legal   = (agb ^ aeb ^ alb) & ~(agb & aeb & alb);
      cnt_inc = cnt_q + SW'(1);
      upd     = guess_q;
      if (agb) begin
         upd[bit_idx_q] = 1'b0;
      end
`ifdef SAR_SEARCH_EARLY_EXIT_EN
      hit = aeb;
`else
      hit = 1'b0;
`endif

      unique case (state_q)
         StIdle: begin
            guess_d = '0;
            busy_d  = 1'b0;
            if (start) begin
               guess_d            = '0;
               guess_d[WIDTH-1]   = 1'b1;
               bit_idx_d          = IW'(WIDTH - 1);
               cnt_d              = '0;
               err_d              = 1'b0;
               busy_d             = 1'b1;
               state_d            = StSearch;
            end
         end
         StSearch: begin
            cnt_d = cnt_inc;
            if (!legal) begin
               // Abort keeps the guess under test, not a half-updated one.
               err_d    = 1'b1;
               result_d = guess_q;
               steps_d  = cnt_inc;
               guess_d  = '0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               state_d  = StDone;
            end else if (hit || bit_idx_q == '0) begin
               result_d = upd;
               steps_d  = cnt_inc;
               guess_d  = '0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               state_d  = StDone;
            end else begin
               bit_idx_d          = bit_idx_q - IW'(1);
               guess_d            = upd;
               guess_d[bit_idx_d] = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            guess_d = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         guess_q   <= '0;
         result_q  <= '0;
         bit_idx_q <= '0;
         cnt_q     <= '0;
         steps_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         guess_q   <= guess_d;
         result_q  <= result_d;
         bit_idx_q <= bit_idx_d;
         cnt_q     <= cnt_d;
         steps_q   <= steps_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign guess  = guess_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign steps  = steps_q;
   assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search with a magnitude comparator in the loop and a binary-search model.
module tb_sar_search;

   localparam int unsigned W  = 4;
   localparam int unsigned SW = $clog2(W + 1);

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          agb, aeb, alb;
   logic [W-1:0]  guess;
   logic          busy, done;
   logic [W-1:0]  result;
   logic [SW-1:0] steps;
   logic          err;

   logic [W-1:0]  target;
   logic          force_en;
   logic [2:0]    force_flags;

   int errors;
   int checks;

   sar_search #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .agb    (agb),
      .aeb    (aeb),
      .alb    (alb),
      .guess  (guess),
      .busy   (busy),
      .done   (done),
      .result (result),
      .steps  (steps),
      .err    (err)
   );

   assign agb = force_en ? force_flags[2] : (guess > target);
   assign aeb = force_en ? force_flags[1] : (guess == target);
   assign alb = force_en ? force_flags[0] : (guess < target);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Binary search over [0, 2^W): each trial adds the next power of two to the
   // largest value known not to exceed the target.
   task automatic model(input int t, output int nsteps, output int gs[W]);
      int lo;
      int g;
      lo = 0;
      nsteps = 0;
      for (int i = 0; i < W; i++) gs[i] = 0;
      for (int b = W - 1; b >= 0; b--) begin
         g = lo + (1 << b);
         gs[nsteps] = g;
         nsteps++;
         if (g <= t) lo = g;
`ifdef SAR_SEARCH_EARLY_EXIT_EN
         if (g == t) break;
`endif
      end
   endtask

   // Runs one search; optionally pulses start in SEARCH cycle poke_at and in DONE.
   task automatic run_search(input int t, input int poke_at, input string tag);
      int exp_n;
      int gs[W];
      int n;
      bit seen;
      model(t, exp_n, gs);
      @(negedge clk);
      target = W'(t);
      start = 1'b1;
      n = 0;
      seen = 1'b0;
      for (int cyc = 0; cyc < 3 * W; cyc++) begin
         @(negedge clk);
         start = (poke_at >= 0 && n + 1 == poke_at) ? 1'b1 : 1'b0;
         if (done) begin
            seen = 1'b1;
            break;
         end
         checks++;
         if (n >= W || guess !== W'(gs[n]) || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s guess[%0d] t=%0d: got %0d busy=%b, want %0d busy=1",
                     tag, n, t, guess, busy, (n < W) ? gs[n] : -1);
         end
         n++;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s timeout t=%0d: no done within %0d cycles", tag, t, 3 * W);
      end
      checks++;
      if (result !== W'(t) || steps !== SW'(exp_n) || err !== 1'b0 || busy !== 1'b0
          || n != exp_n) begin
         errors++;
         $display("FAIL %s outcome t=%0d: got result=%0d steps=%0d err=%b busy=%b cycles=%0d, want result=%0d steps=%0d err=0 busy=0",
                  tag, t, result, steps, err, busy, n, t, exp_n);
      end
      start = (poke_at >= 0) ? 1'b1 : 1'b0;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || guess !== '0) begin
         errors++;
         $display("FAIL %s post-done t=%0d: got done=%b busy=%b guess=%0d, want 0 0 0",
                  tag, t, done, busy, guess);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      force_en = 1'b0;
      force_flags = 3'b000;
      target = '0;
      #12;
      checks++;
      if ({guess, busy, done, result, steps, err} !== '0) begin
         errors++;
         $display("FAIL reset: got guess=%0d busy=%b done=%b result=%0d steps=%0d err=%b, want all 0",
                  guess, busy, done, result, steps, err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || guess !== '0) begin
         errors++;
         $display("FAIL idle: got busy=%b guess=%0d, want 0 0", busy, guess);
      end
   endtask

   task automatic test_directed();
      run_search(4, -1, "t4");
      run_search(0, -1, "t0");
      run_search(15, -1, "t15");
   endtask

   task automatic test_illegal();
      @(negedge clk);
      target = 4'd4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      force_en = 1'b1;
      force_flags = 3'b000;
      @(negedge clk);
      force_en = 1'b0;
      checks++;
      if (done !== 1'b1 || err !== 1'b1 || result !== 4'd4 || steps !== SW'(2)) begin
         errors++;
         $display("FAIL illegal: got done=%b err=%b result=%0d steps=%0d, want 1 1 4 2",
                  done, err, result, steps);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || err !== 1'b1) begin
         errors++;
         $display("FAIL illegal-hold: got done=%b err=%b, want done=0 err=1", done, err);
      end
      target = 4'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL err-clear: got err=%b busy=%b, want 0 1", err, busy);
      end
      repeat (2 * W) @(negedge clk);
   endtask

   task automatic test_start_while_busy();
      run_search(9, 2, "busy-start");
      run_search(6, 1, "busy-start2");
   endtask

   task automatic test_reset_mid();
      bit pulsed;
      @(negedge clk);
      target = 4'd11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({guess, busy, done, result, steps, err} !== '0) begin
         errors++;
         $display("FAIL reset-mid: got guess=%0d busy=%b done=%b result=%0d steps=%0d err=%b, want all 0",
                  guess, busy, done, result, steps, err);
      end
      pulsed = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (W + 2) begin
         @(negedge clk);
         if (done || busy) pulsed = 1'b1;
      end
      checks++;
      if (pulsed) begin
         errors++;
         $display("FAIL reset-mid-idle: got done/busy activity after reset, want none");
      end
   endtask

   task automatic test_sweep();
      for (int t = 0; t < (1 << W); t++) run_search(t, -1, "sweep");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 12; i++)
         run_search(int'($urandom_range((1 << W) - 1, 0)), -1, "random");
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_directed();
      test_illegal();
      test_start_while_busy();
      test_reset_mid();
      test_sweep();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the search word width in bits; legal range is 2..16.
REQ-002 Port clk: input, 1 bit; the single clock, with all state updating on its rising edge.
REQ-003 Port rst_n: input, 1 bit; reset is asynchronous and active-low.
REQ-004 Port start: input, 1 bit; a request to begin a search, sampled only in IDLE.
REQ-005 Port agb: input, 1 bit; external comparator flag, guess > target.
REQ-006 Port aeb: input, 1 bit; external comparator flag, guess == target.
REQ-007 Port alb: input, 1 bit; external comparator flag, guess < target.
REQ-008 Port guess: output, WIDTH bits; the trial value driven to the external comparator "a" input.
REQ-009 Port busy: output, 1 bit; high while in SEARCH.
REQ-010 Port done: output, 1 bit; a one-cycle pulse when result is valid.
REQ-011 Port result: output, WIDTH bits; the final search value, held until the next search completes.
REQ-012 Port steps: output, $clog2(WIDTH+1) bits; the number of SEARCH cycles used by the last search.
REQ-013 Port err: output, 1 bit; high if the last search aborted on illegal flags.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SEARCH and DONE.
REQ-015 IDLE SHALL behave as follows:
- guess = 0, busy = 0.
- On start = 1: load bit_idx = WIDTH-1, guess = 1 << (WIDTH-1), clear step counter and err, go to SEARCH.
REQ-016 SEARCH SHALL sample the flags once per cycle against the current guess, which is combinationally compared externally in the same cycle.
REQ-017 In SEARCH, agb = 1 SHALL clear guess[bit_idx]; alb = 1 SHALL keep it; each SEARCH cycle increments the step counter.
REQ-018 In SEARCH, when bit_idx > 0 and the search has not terminated, the block SHALL decrement bit_idx and set the new guess[bit_idx].
REQ-019 When bit_idx == 0, or on early exit, the block SHALL register result = updated guess and steps = count including the current cycle, then go to DONE.
REQ-020 Illegal flags in SEARCH (agb, aeb, alb not exactly one-hot) SHALL set err = 1 and result = current guess, then go to DONE.
REQ-021 DONE SHALL last one cycle with done = 1 and busy = 0, then go to IDLE.
REQ-022 start SHALL be ignored in SEARCH and in DONE; a new search begins only from IDLE.
REQ-023 Worst-case latency SHALL be WIDTH SEARCH cycles, with done asserted the cycle after the last SEARCH cycle.
REQ-024 result, steps and err SHALL hold their values until overwritten at the end of the next search.

Reset
REQ-025 rst_n = 0 SHALL immediately force state = IDLE and all outputs to zero: guess, busy, done, result, steps and err.
REQ-026 Reset asserted mid-SEARCH SHALL abandon the search with no done pulse; after release the block waits in IDLE for start.

Configuration
REQ-027 With SAR_SEARCH_EARLY_EXIT_EN defined, aeb = 1 in SEARCH SHALL register result = guess and go to DONE immediately.
REQ-028 Without SAR_SEARCH_EARLY_EXIT_EN, aeb SHALL be treated as alb (keep bit), and every legal search SHALL take exactly WIDTH steps.

Structure
REQ-029 Package sar_pkg SHALL hold the state enum (IDLE, SEARCH, DONE) and the WIDTH default constant.
REQ-030 No sub-module SHALL be used: the comparator is external, and the bench pairs the block with a combinational magnitude comparator (a = guess, b = target).

Verification (WIDTH = 4, comparator in loop)
REQ-031 With EARLY_EXIT, target 4: guesses 8 then 4 -> done, result = 4, steps = 2, err = 0.
REQ-032 Target 0: guesses 8, 4, 2, 1 all agb -> result = 0, steps = 4; target 15: guesses 8, 12, 14, 15 -> result = 15, steps = 4.
REQ-033 Without EARLY_EXIT, target 4: guesses 8, 4, 6, 5 -> result = 4, steps = 4.
REQ-034 Flags forced to 000 in the second SEARCH cycle -> err = 1, result = 4, steps = 2, one done pulse; err clears on the next start.
REQ-035 Directed reset and start checks SHALL pass:
- start pulsed while busy -> no restart, guess sequence unaffected.
- rst_n low mid-search -> all outputs 0 asynchronously, no done pulse.
REQ-036 An exhaustive sweep of targets 0..15 in both configurations -> result == target on every search.
